regfile_sb: RTL
===============

# regfile_sb

Parametrised register file with internal write-before-read bypass and a per-register busy scoreboard, each storage bit being a write-enabled flop. Sits in the decode stage of the pipelined core. It supplies two source operands per cycle. It accepts one writeback per cycle. It tracks which destination registers have an in-flight producer, so hazard/stall logic can consume the busy flags directly.

## Interface
- WIDTH, 16, data width of each register
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1: register 0 reads 0, ignores writes, is never busy
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset; clears all state immediately when low
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  WIDTH  read port 1 data (combinational)
- rd_data2  output  WIDTH  read port 2 data (combinational)
- busy1  output  1  scoreboard flag for rd_addr1 (combinational)
- busy2  output  1  scoreboard flag for rd_addr2 (combinational)
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback address
- wr_data  input  WIDTH  writeback data
- iss_en  input  1  issue strobe: marks iss_addr as having an in-flight producer
- iss_addr  input  ADDR_W  destination of issuing instruction
- busy_cnt  output  ADDR_W+1  number of registers currently busy (registered)

## Operation
- Storage: DEPTH x WIDTH flops; reg[wr_addr] <= wr_data on edge when wr_en=1 and rst=1; all other registers hold.
- Read: rd_dataN = reg[rd_addrN], except bypass: if wr_en=1 and wr_addr==rd_addrN, rd_dataN = wr_data in the same cycle.
- Both ports may read the same address; both may bypass simultaneously.
- Scoreboard: busy[DEPTH] bits.
  - iss_en sets busy[iss_addr].
  - wr_en clears busy[wr_addr].
- Same edge, iss_addr==wr_addr, both strobes high: busy ends 1, because the new producer wins. Data is still written.
- Same edge, different addresses: both updates apply.
- iss_en on an already-busy register: stays 1, no count change.
- wr_en on a non-busy register: data written, busy stays 0.
- busyN = busy[rd_addrN] & ~(wr_en & wr_addr==rd_addrN). A matching writeback hides busy because the data is bypassed.
- busy_cnt: registered popcount of busy, updated on the same edge as busy. Net change per edge is in {-1, 0, +1}. Maximum value is DEPTH, so it never wraps.
- ZERO_REG=1:
  - rd_dataN = 0 and busyN = 0 whenever rd_addrN==0, bypass included.
  - Writes and issues to 0 are dropped and busy_cnt is unaffected.
- Reset (rst low, async):
  - All registers, busy bits and busy_cnt go to 0 immediately.
  - While rst is low: rd_data1/2 = 0, busy1/2 = 0; wr_en and iss_en are ignored; no bypass.
- Reset deassertion: the first edge with rst=1 accepts writes/issues normally.

## Timing
- Read latency 0: combinational from rd_addr, wr_en/wr_addr/wr_data.
- Write latency 1: value visible from reg array on the cycle after the wr_en edge. It is visible via bypass in the wr_en cycle itself.
- Issue latency 1: busy visible on the cycle after the iss_en edge.
- Reset mid-operation: any write/issue pending on the edge coincident with rst low is lost.
- Reset values: rd_data1=rd_data2=0, busy1=busy2=0, busy_cnt=0.
- No combinational path from iss_* to any output.

## Test plan
- Reset then write:
  - rst low 2 cycles, then wr_en=1 wr_addr=3 wr_data=16'hBEEF, rd_addr1=3 -> rd_data1=16'hBEEF in the same cycle via bypass.
  - Next cycle, wr_en=0 -> still 16'hBEEF.
  - rd_addr2=4 -> 0.
- Scoreboard set/clear:
  - iss_en addr 5 -> next cycle busy1=1 at rd_addr1=5, busy_cnt=1.
  - wr_en addr 5 data 16'h0042 -> busy1=0 in that cycle, data 16'h0042.
  - Next cycle, busy_cnt=0.
- Simultaneous:
  - busy[2]=1; iss_en and wr_en both addr 2, data 16'h1234 -> next cycle reg[2]=16'h1234, busy[2]=1, busy_cnt unchanged.
  - Separately, iss 6 with wb 2 -> busy_cnt unchanged, busy[6]=1, busy[2]=0.
- Full count: issue all 8 addresses over 8 cycles -> busy_cnt=8. Re-issue addr 0 -> busy_cnt stays 8.
- ZERO_REG=1: wr_en addr 0 data 16'hFFFF and iss_en addr 0 -> rd_data1=0, busy1=0, busy_cnt=0, in both the write cycle and after.
- Async reset mid-op: with regs written and busy_cnt=3, pull rst low between edges -> all outputs 0 before the next edge. After release, reg[3] reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-before-read bypass and per-register busy scoreboard
// Ports:
//   clk, rst (async, active-low)
//   rd_addr1/2 -> rd_data1/2, busy1/2 : combinational read ports with bypass
//   wr_en, wr_addr, wr_data           : one writeback per cycle, clears busy
//   iss_en, iss_addr                  : one issue per cycle, sets busy
//   busy_cnt                          : registered count of busy registers
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             we, ie;
  // Gating we with rst also kills the bypass while in reset; register 0 is never
  // written or marked busy when hardwired, so it naturally reads 0 / not busy.
  assign we = rst & wr_en & !(ZERO_REG && wr_addr == '0);
  assign ie = iss_en & !(ZERO_REG && iss_addr == '0);
  // Issue is applied after the writeback clear so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[wr_addr] = 1'b0;
    if (ie) busy_nxt[iss_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end
  assign rd_data1 = (we && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
  assign rd_data2 = (we && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
  assign busy1    = busy[rd_addr1] & !(we && wr_addr == rd_addr1);
  assign busy2    = busy[rd_addr2] & !(we && wr_addr == rd_addr2);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (we) regs[wr_addr] <= wr_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule
